// File: rtl/btb_rt_upd_queue_if.sv
// Retire-update bundle between retire/BTB and the update queue.
// Slave modport is the queue side, master is the retire/BTB side.
interface btb_rt_upd_queue_if #(
    parameter int DROP_CNT_W = 16
);
    logic                  rt0_vld;
    logic [63:0]           rt0_brpc;
    logic                  rt0_brdir;
    logic [63:0]           rt0_brtar;
    logic                  rt1_vld;
    logic [63:0]           rt1_brpc;
    logic                  rt1_brdir;
    logic [63:0]           rt1_brtar;
    logic                  btb_sp_we;
    logic                  rt_ready;
    logic                  btb_rt_we;
    logic [63:0]           btb_rt_brpc;
    logic                  btb_rt_brdir;
    logic [63:0]           btb_rt_brtar;
    logic                  q_empty;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output rt0_vld, rt0_brpc, rt0_brdir, rt0_brtar,
        output rt1_vld, rt1_brpc, rt1_brdir, rt1_brtar,
        output btb_sp_we,
        input  rt_ready, btb_rt_we, btb_rt_brpc, btb_rt_brdir, btb_rt_brtar,
        input  q_empty, drop_cnt
    );

    modport slave (
        input  rt0_vld, rt0_brpc, rt0_brdir, rt0_brtar,
        input  rt1_vld, rt1_brpc, rt1_brdir, rt1_brtar,
        input  btb_sp_we,
        output rt_ready, btb_rt_we, btb_rt_brpc, btb_rt_brdir, btb_rt_brtar,
        output q_empty, drop_cnt
    );
endinterface

// File: rtl/btb_rt_upd_queue.sv
// Buffers up to two retired branch updates per cycle and drains one per cycle to the BTB retire port.
// Latency >= 1 cycle; drain yields to btb_sp_we, overflow beyond free space is dropped and counted.
module btb_rt_upd_queue #(
    parameter int DEPTH      = 8,
    parameter int PTR_W      = 3,
    parameter int DROP_CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    btb_rt_upd_queue_if.slave bus
);
    typedef struct packed {
        logic [63:0] pc;
        logic        dir;
        logic [63:0] tar;
    } upd_t;

    localparam logic [PTR_W:0] DEPTH_C   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

    upd_t                  mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      wr_ptr_nxt1;
    logic [PTR_W:0]        count;
    logic [PTR_W:0]        count_nxt;
    logic [PTR_W:0]        free;
    logic [DROP_CNT_W-1:0] drop_cnt;
    logic [DROP_CNT_W:0]   drop_sum;
    logic                  ready_q;
    logic                  empty;
    logic                  pop;
    logic [1:0]            n_req;
    logic [1:0]            n_acc;
    logic [1:0]            n_drop;
    upd_t                  slot0;
    upd_t                  slot1;
    upd_t                  first;

    always_comb begin
        slot0.pc  = bus.rt0_brpc;
        slot0.dir = bus.rt0_brdir;
        slot0.tar = bus.rt0_brtar;
        slot1.pc  = bus.rt1_brpc;
        slot1.dir = bus.rt1_brdir;
        slot1.tar = bus.rt1_brtar;

        empty = (count == '0);
        pop   = !empty && !bus.btb_sp_we;
        // The same-cycle pop frees a slot, so a full queue still takes one entry.
        free  = DEPTH_C - count + {{PTR_W{1'b0}}, pop};
        n_req = {1'b0, bus.rt0_vld} + {1'b0, bus.rt1_vld};

        if (free >= (PTR_W+1)'(2)) begin
            n_acc = n_req;
        end else if (free == (PTR_W+1)'(1)) begin
            n_acc = (n_req != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            n_acc = 2'd0;
        end
        n_drop = n_req - n_acc;

        // A lone slot 1 behaves as a single push into the first free entry.
        first       = bus.rt0_vld ? slot0 : slot1;
        wr_ptr_nxt1 = wr_ptr + PTR_W'(1);
        count_nxt   = count + {{(PTR_W-1){1'b0}}, n_acc} - {{PTR_W{1'b0}}, pop};
        drop_sum    = {1'b0, drop_cnt} + {{(DROP_CNT_W-1){1'b0}}, n_drop};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            wr_ptr   <= wr_ptr + PTR_W'(n_acc);
            count    <= count_nxt;
            ready_q  <= (count_nxt <= READY_MAX);
            drop_cnt <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (n_acc != 2'd0) begin
            mem[wr_ptr] <= first;
        end
        if (n_acc == 2'd2) begin
            mem[wr_ptr_nxt1] <= slot1;
        end
    end

    assign bus.btb_rt_we    = pop;
    assign bus.btb_rt_brpc  = empty ? 64'd0 : mem[rd_ptr].pc;
    assign bus.btb_rt_brdir = empty ? 1'b0  : mem[rd_ptr].dir;
    assign bus.btb_rt_brtar = empty ? 64'd0 : mem[rd_ptr].tar;
    assign bus.q_empty      = empty;
    assign bus.rt_ready     = ready_q;
    assign bus.drop_cnt     = drop_cnt;
endmodule

// File: tb/tb_btb_rt_upd_queue.sv
// Directed bench for btb_rt_upd_queue with a queue-based scoreboard of expected BTB updates.
module tb_btb_rt_upd_queue;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int DW    = 16;

    typedef struct packed {
        logic [63:0] pc;
        logic        dir;
        logic [63:0] tar;
    } upd_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    btb_rt_upd_queue_if #(.DROP_CNT_W(DW)) bus ();

    btb_rt_upd_queue #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W),
        .DROP_CNT_W(DW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    upd_t sbq[$];
    int   mdrop  = 0;
    int   checks = 0;
    int   errors = 0;
    upd_t none;

    function automatic upd_t mk(input logic [63:0] pc);
        upd_t u;
        u.pc  = pc;
        u.dir = pc[2];
        u.tar = pc + 64'h40;
        return u;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input upd_t u);
        if (sbq.size() < DEPTH) sbq.push_back(u);
        else mdrop++;
    endtask

    task automatic clear_inputs();
        bus.rt0_vld   = 1'b0;
        bus.rt0_brpc  = '0;
        bus.rt0_brdir = 1'b0;
        bus.rt0_brtar = '0;
        bus.rt1_vld   = 1'b0;
        bus.rt1_brpc  = '0;
        bus.rt1_brdir = 1'b0;
        bus.rt1_brtar = '0;
        bus.btb_sp_we = 1'b0;
    endtask

    // One cycle: drive inputs, check outputs mid-cycle against the scoreboard, advance the model.
    task automatic tick(input bit v0, input upd_t s0, input bit v1, input upd_t s1, input bit sp);
        bit exp_we;
        bus.rt0_vld   = v0;
        bus.rt0_brpc  = s0.pc;
        bus.rt0_brdir = s0.dir;
        bus.rt0_brtar = s0.tar;
        bus.rt1_vld   = v1;
        bus.rt1_brpc  = s1.pc;
        bus.rt1_brdir = s1.dir;
        bus.rt1_brtar = s1.tar;
        bus.btb_sp_we = sp;
        @(negedge clock);
        exp_we = (sbq.size() != 0) && !sp;
        chk("q_empty", bus.q_empty, sbq.size() == 0);
        chk("rt_ready", bus.rt_ready, sbq.size() <= DEPTH - 2);
        chk("drop_cnt", bus.drop_cnt, mdrop);
        chk("btb_rt_we", bus.btb_rt_we, exp_we);
        if (sbq.size() != 0) begin
            chk("head_pc", bus.btb_rt_brpc, sbq[0].pc);
            chk("head_dir", bus.btb_rt_brdir, sbq[0].dir);
            chk("head_tar", bus.btb_rt_brtar, sbq[0].tar);
        end else begin
            chk("empty_pc", bus.btb_rt_brpc, 64'd0);
            chk("empty_tar", bus.btb_rt_brtar, 64'd0);
        end
        if (exp_we) void'(sbq.pop_front());
        if (v0) model_push(s0);
        if (v1) model_push(s1);
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic idle(input bit sp);
        tick(1'b0, none, 1'b0, none, sp);
    endtask

    task automatic drain();
        int guard = 0;
        while (sbq.size() != 0 && guard < 32) begin
            idle(1'b0);
            guard++;
        end
        chk("drain_done", sbq.size(), 0);
    endtask

    initial begin
        none = '0;
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_q_empty", bus.q_empty, 1'b1);
        chk("rst_we", bus.btb_rt_we, 1'b0);
        chk("rst_pc", bus.btb_rt_brpc, 64'd0);
        chk("rst_tar", bus.btb_rt_brtar, 64'd0);
        chk("rst_ready", bus.rt_ready, 1'b1);
        chk("rst_drop", bus.drop_cnt, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single push, visible the following cycle then gone.
        tick(1'b1, '{pc: 64'h1000, dir: 1'b1, tar: 64'h2000}, 1'b0, none, 1'b0);
        chk("single_we", bus.btb_rt_we, 1'b1);
        chk("single_pc", bus.btb_rt_brpc, 64'h1000);
        chk("single_tar", bus.btb_rt_brtar, 64'h2000);
        idle(1'b0);
        idle(1'b0);

        // Dual push ordering, plus lone slot 1.
        tick(1'b1, mk(64'h100), 1'b1, mk(64'h200), 1'b0);
        idle(1'b0);
        idle(1'b0);
        tick(1'b0, none, 1'b1, mk(64'h240), 1'b0);
        drain();

        // Speculative hold-off for three cycles.
        tick(1'b1, mk(64'h300), 1'b0, none, 1'b0);
        repeat (3) idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        // Fill with drain blocked, then overflow by a dual push.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, mk(64'h400 + 64'(i * 16)), 1'b1, mk(64'h408 + 64'(i * 16)), 1'b1);
        end
        tick(1'b1, mk(64'h4f0), 1'b1, mk(64'h4f8), 1'b1);
        chk("ovf_drop", bus.drop_cnt, 2);
        chk("ovf_ready", bus.rt_ready, 1'b0);
        idle(1'b1);

        // Full queue with a pop in the same cycle accepts exactly one.
        tick(1'b1, mk(64'h500), 1'b1, mk(64'h508), 1'b0);
        chk("fullpop_drop", bus.drop_cnt, 3);
        chk("fullpop_ready", bus.rt_ready, 1'b0);
        drain();

        // Sequential PCs across several pointer wraps.
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, mk(64'h8000 + 64'(i * 8)), 1'b1, mk(64'h8004 + 64'(i * 8)), 1'b0);
            idle(1'b0);
        end
        tick(1'b1, mk(64'h9000), 1'b1, mk(64'h9004), 1'b1);
        tick(1'b1, mk(64'h9008), 1'b1, mk(64'h900c), 1'b1);

        // Asynchronous reset mid-stream discards everything immediately.
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_q_empty", bus.q_empty, 1'b1);
        chk("midrst_we", bus.btb_rt_we, 1'b0);
        chk("midrst_drop", bus.drop_cnt, 0);
        chk("midrst_ready", bus.rt_ready, 1'b1);
        chk("midrst_pc", bus.btb_rt_brpc, 64'd0);
        sbq.delete();
        mdrop = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick(1'b1, mk(64'ha000), 1'b0, none, 1'b0);
        idle(1'b0);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
